// File: rtl/envelope_lane_split.sv
// rtl/envelope_lane_split.sv - splits one packed multi-lane CHDR stream into per-lane packet streams
//
// envelope_lane_split_fifo : first-word-fall-through FIFO, 2**AW entries of W bits.
//   flush clears occupancy; push and pop in the same cycle are allowed even when full.
//
// envelope_lane_split : top level.
//   clk, reset, clear          : clock, sync active-high reset, sync flush
//   next_dst[16*NUM_CH]        : per-lane destination SID, sampled when a header is pushed
//   i_tdata/i_tuser/i_tlast/i_tvalid/i_tready : packed input stream + CHDR header
//   o_tdata/o_tuser/o_tlast/o_tvalid/o_tready : NUM_CH independent lane streams
//   hdr_overflow               : sticky, set when a lane has data but no header

module envelope_lane_split_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [1<<AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

module envelope_lane_split #(
  parameter int NUM_CH         = 2,
  parameter int WIDTH          = 16,
  parameter int PAD_MODE       = 1,
  parameter int DATA_FIFO_SIZE = 5,
  parameter int HDR_FIFO_SIZE  = 2,
  localparam int OW            = (PAD_MODE != 0) ? 2*WIDTH : WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [16*NUM_CH-1:0]    next_dst,
  input  logic [NUM_CH*WIDTH-1:0] i_tdata,
  input  logic [127:0]            i_tuser,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [NUM_CH*OW-1:0]    o_tdata,
  output logic [128*NUM_CH-1:0]   o_tuser,
  output logic [NUM_CH-1:0]       o_tlast,
  output logic [NUM_CH-1:0]       o_tvalid,
  input  logic [NUM_CH-1:0]       o_tready,
  output logic                    hdr_overflow
);

  logic              flush;
  logic              sof;
  logic              accept;
  logic              hdr_push;
  logic [NUM_CH-1:0] data_full;
  logic [NUM_CH-1:0] hdr_full;
  logic [NUM_CH-1:0] hdr_err;
  logic              unused_src;

  // The incoming src SID is replaced per lane; only its dst field feeds the new src.
  assign unused_src = ^i_tuser[95:80];

  assign flush    = reset || clear;
  // Header room is only needed when this beat opens a new packet.
  assign i_tready = !reset && !(|data_full) && (!sof || !(|hdr_full));
  assign accept   = i_tvalid && i_tready;
  assign hdr_push = accept && sof;

  always_ff @(posedge clk) begin
    if (flush) begin
      sof <= 1'b1;
    end else if (accept) begin
      sof <= i_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      hdr_overflow <= 1'b0;
    end else if (|hdr_err) begin
      hdr_overflow <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    localparam logic [3:0] LANE_ID = 4'(k);

    logic [WIDTH:0] d_dout;
    logic           d_empty;
    logic [127:0]   h_din;
    logic [127:0]   h_dout;
    logic           h_empty;
    logic           h_pop;

    assign h_din = {i_tuser[127:96], i_tuser[79:68], LANE_ID,
                    next_dst[16*k +: 16], i_tuser[63:0]};

    envelope_lane_split_fifo #(.W(WIDTH+1), .AW(DATA_FIFO_SIZE)) u_data_fifo (
      .clk   (clk),
      .flush (flush),
      .push  (accept),
      .din   ({i_tlast, i_tdata[(NUM_CH-k)*WIDTH-1 -: WIDTH]}),
      .pop   (o_tready[k]),
      .dout  (d_dout),
      .empty (d_empty),
      .full  (data_full[k])
    );

    // Header retires with the last beat of its packet.
    assign h_pop = o_tvalid[k] && o_tready[k] && o_tlast[k];

    envelope_lane_split_fifo #(.W(128), .AW(HDR_FIFO_SIZE)) u_hdr_fifo (
      .clk   (clk),
      .flush (flush),
      .push  (hdr_push),
      .din   (h_din),
      .pop   (h_pop),
      .dout  (h_dout),
      .empty (h_empty),
      .full  (hdr_full[k])
    );

    assign o_tvalid[k] = !d_empty;
    assign o_tlast[k]  = d_dout[WIDTH];
    assign hdr_err[k]  = !d_empty && h_empty;
    assign o_tuser[128*k +: 128] = h_empty ? 128'd0 : h_dout;

    if (PAD_MODE != 0) begin : g_pad
      assign o_tdata[OW*k +: OW] = {d_dout[WIDTH-1:0], {WIDTH{1'b0}}};
    end else begin : g_nopad
      assign o_tdata[OW*k +: OW] = d_dout[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_envelope_lane_split.sv
// tb/tb_envelope_lane_split.sv - directed self-checking bench for envelope_lane_split
module tb_envelope_lane_split;

  typedef struct packed {
    logic [31:0]  d;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;

  logic [31:0]  next_dst = {16'h0056, 16'h0078};
  logic [31:0]  i_tdata = '0;
  logic [127:0] i_tuser = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [63:0]  o_tdata;
  logic [255:0] o_tuser;
  logic [1:0]   o_tlast;
  logic [1:0]   o_tvalid;
  logic [1:0]   o_tready = 2'b11;
  logic         hdr_overflow;

  logic [63:0]  b_next_dst = {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00};
  logic [31:0]  b_i_tdata = '0;
  logic [127:0] b_i_tuser = '0;
  logic         b_i_tlast = 1'b0;
  logic         b_i_tvalid = 1'b0;
  logic         b_i_tready;
  logic [31:0]  b_o_tdata;
  logic [511:0] b_o_tuser;
  logic [3:0]   b_o_tlast;
  logic [3:0]   b_o_tvalid;
  logic [3:0]   b_o_tready = 4'h0;
  logic         b_hdr_overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  envelope_lane_split dut (
    .clk(clk), .reset(reset), .clear(clear), .next_dst(next_dst),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .hdr_overflow(hdr_overflow)
  );

  envelope_lane_split #(.NUM_CH(4), .WIDTH(8), .PAD_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .next_dst(b_next_dst),
    .i_tdata(b_i_tdata), .i_tuser(b_i_tuser), .i_tlast(b_i_tlast),
    .i_tvalid(b_i_tvalid), .i_tready(b_i_tready),
    .o_tdata(b_o_tdata), .o_tuser(b_o_tuser), .o_tlast(b_o_tlast),
    .o_tvalid(b_o_tvalid), .o_tready(b_o_tready), .hdr_overflow(b_hdr_overflow)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (o_tvalid[0] && o_tready[0]) q0.push_back({o_tdata[31:0], o_tuser[127:0], o_tlast[0]});
      if (o_tvalid[1] && o_tready[1]) q1.push_back({o_tdata[63:32], o_tuser[255:128], o_tlast[1]});
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [127:0] u, input logic [3:0] k,
                                          input logic [15:0] dst);
    return {u[127:96], u[79:68], k, dst, u[63:0]};
  endfunction

  task automatic send(input logic [31:0] d, input logic [127:0] u, input logic l);
    bit ok = 0;
    int n = 0;
    i_tdata = d; i_tuser = u; i_tlast = l; i_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = i_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic expect_beat(input string tag, input int lane, input logic [31:0] d,
                             input logic [127:0] u, input logic l);
    beat_t b;
    int sz = (lane == 0) ? q0.size() : q1.size();
    check({tag, "_avail"}, 128'(sz > 0), 1);
    if (sz == 0) return;
    if (lane == 0) b = q0.pop_front();
    else b = q1.pop_front();
    check({tag, "_data"}, b.d, d);
    check({tag, "_user"}, b.u, u);
    check({tag, "_last"}, b.l, l);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_tvalid != 2'b00 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", o_tvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] u;
    logic [127:0] u2;
    int acc;
    int c0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_tready", i_tready, 0);
    check("rst_o_tvalid", o_tvalid, 0);
    check("rst_hdr_ovf", hdr_overflow, 0);
    reset = 1'b0;
    #1;
    check("post_rst_i_tready", i_tready, 1);

    // 4-beat packet, hand-computed headers
    u = {32'hC0DE_0001, 32'h0012_0034, 64'h0123_4567_89AB_CDEF};
    send(32'hAAAA_5555, u, 1'b0);
    check("latency_o_tvalid", o_tvalid, 2'b11);
    send(32'hAAAA_5555, u, 1'b0);
    send(32'hAAAA_5555, u, 1'b0);
    send(32'hAAAA_5555, u, 1'b1);
    i_tvalid = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      expect_beat("t1_l0", 0, 32'hAAAA_0000,
                  {32'hC0DE_0001, 16'h0030, 16'h0078, 64'h0123_4567_89AB_CDEF}, i == 3);
      expect_beat("t1_l1", 1, 32'h5555_0000,
                  {32'hC0DE_0001, 16'h0031, 16'h0056, 64'h0123_4567_89AB_CDEF}, i == 3);
    end

    // lane1 stalled: header FIFO (4 deep) limits acceptance
    o_tready = 2'b01;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      i_tdata = {16'(16'h1000 + i), 16'(16'h2000 + i)};
      i_tuser = {32'(32'h1111_0000 + i), 16'h0BEE, 16'h0C40, 64'(i)};
      i_tlast = 1'b1;
      i_tvalid = 1'b1;
      @(negedge clk);
      if (!i_tready) break;
      @(posedge clk); #1;
      acc++;
    end
    i_tvalid = 1'b0;
    check("stall_accepts", acc, 4);
    repeat (2) @(posedge clk);
    #1;
    check("stall_ready_low", i_tready, 0);
    check("stall_lane0_count", q0.size(), 4);
    check("stall_lane1_valid", o_tvalid[1], 1);
    for (int i = 0; i < 4; i++) begin
      u = {32'(32'h1111_0000 + i), 16'h0BEE, 16'h0C40, 64'(i)};
      expect_beat("t2_l0", 0, {16'(16'h1000 + i), 16'h0}, mk_hdr(u, 4'd0, 16'h0078), 1'b1);
    end
    o_tready = 2'b11;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      u = {32'(32'h1111_0000 + i), 16'h0BEE, 16'h0C40, 64'(i)};
      expect_beat("t2_l1", 1, {16'(16'h2000 + i), 16'h0}, mk_hdr(u, 4'd1, 16'h0056), 1'b1);
    end

    // back-to-back single-beat packets, no bubbles
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send({16'(16'h3000 + i), 16'(16'h4000 + i)},
           {32'h2222_0000, 16'h0111, 16'(16'h0A00 + 16 * i), 64'(100 + i)}, 1'b1);
    check("b2b_cycles", cyc - c0, 8);
    i_tvalid = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      u = {32'h2222_0000, 16'h0111, 16'(16'h0A00 + 16 * i), 64'(100 + i)};
      expect_beat("t3_l0", 0, {16'(16'h3000 + i), 16'h0}, mk_hdr(u, 4'd0, 16'h0078), 1'b1);
      expect_beat("t3_l1", 1, {16'(16'h4000 + i), 16'h0}, mk_hdr(u, 4'd1, 16'h0056), 1'b1);
    end

    // next_dst change mid-packet
    u  = {32'h3333_0000, 16'h0222, 16'h0F70, 64'h55};
    u2 = {32'h3333_0001, 16'h0222, 16'h0F80, 64'h56};
    send(32'h0001_0002, u, 1'b0);
    next_dst = {16'h0BBB, 16'h0AAA};
    send(32'h0003_0004, u, 1'b0);
    send(32'h0005_0006, u, 1'b1);
    send(32'h0007_0008, u2, 1'b1);
    i_tvalid = 1'b0;
    wait_idle();
    expect_beat("t4_b1", 0, 32'h0001_0000, mk_hdr(u, 4'd0, 16'h0078), 1'b0);
    expect_beat("t4_b2", 0, 32'h0003_0000, mk_hdr(u, 4'd0, 16'h0078), 1'b0);
    expect_beat("t4_b3", 0, 32'h0005_0000, mk_hdr(u, 4'd0, 16'h0078), 1'b1);
    expect_beat("t4_p2", 0, 32'h0007_0000, mk_hdr(u2, 4'd0, 16'h0AAA), 1'b1);
    expect_beat("t4_l1b1", 1, 32'h0002_0000, mk_hdr(u, 4'd1, 16'h0056), 1'b0);
    q1.delete();

    // clear mid-packet with lanes stalled
    o_tready = 2'b00;
    u = {32'h4444_0000, 16'h0333, 16'h0E50, 64'h77};
    send(32'h0009_000A, u, 1'b0);
    send(32'h000B_000C, u, 1'b0);
    i_tvalid = 1'b0;
    check("clr_pre_valid", o_tvalid, 2'b11);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_o_tvalid", o_tvalid, 0);
    check("clr_i_tready", i_tready, 1);
    o_tready = 2'b11;
    u2 = {32'h4444_0001, 16'h0333, 16'h0E60, 64'h78};
    send(32'h000D_000E, u2, 1'b1);
    i_tvalid = 1'b0;
    wait_idle();
    check("clr_q0_count", q0.size(), 1);
    expect_beat("t5_l0", 0, 32'h000D_0000, mk_hdr(u2, 4'd0, 16'h0AAA), 1'b1);
    expect_beat("t5_l1", 1, 32'h000E_0000, mk_hdr(u2, 4'd1, 16'h0BBB), 1'b1);
    check("hdr_ovf_final", hdr_overflow, 0);

    // 4 lanes, 8-bit, unpadded
    b_i_tdata  = 32'h1122_3344;
    b_i_tuser  = {32'h5555_0000, 16'h0999, 16'h0AB0, 64'hFEED};
    b_i_tlast  = 1'b1;
    b_i_tvalid = 1'b1;
    check("b_i_tready", b_i_tready, 1);
    @(posedge clk); #1;
    b_i_tvalid = 1'b0;
    check("b_o_tvalid", b_o_tvalid, 4'hF);
    check("b_o_tdata", b_o_tdata, 32'h4433_2211);
    check("b_o_tlast", b_o_tlast, 4'hF);
    for (int k = 0; k < 4; k++)
      check($sformatf("b_sid_l%0d", k), b_o_tuser[128*k+64 +: 32],
            {16'(16'h0AB0 + k), 16'(16'h0D00 + k)});
    check("b_time_l3", b_o_tuser[3*128 +: 64], 64'hFEED);
    b_o_tready = 4'hF;
    @(posedge clk); #1;
    check("b_drained", b_o_tvalid, 0);
    check("b_hdr_ovf", b_hdr_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_lane_split.md
Name: envelope_lane_split

Overview:
- Parametrised successor to the two-port magnitude/phase splitter used in the envelope block.
- Takes one deframed stream whose beats pack NUM_CH lane samples, plus its 128-bit CHDR header on tuser. Produces NUM_CH independent packetised lane streams, each with its own rewritten header, ready for per-lane chdr_framer instances.
- Each lane has its own data FIFO and header FIFO, so lanes drain independently without the lockstep stall of the old design.
- Sits between the processing core (e.g. complex_to_magphase) and the framers inside a noc_block.

Parameters:
NUM_CH, 2, number of output lanes (1..16)
WIDTH, 16, bits per lane sample
PAD_MODE, 1, 1: output word is 2*WIDTH, with the sample in the upper half and zeros below (SC16-style); 0: output word is WIDTH
DATA_FIFO_SIZE, 5, log2 depth of each lane data FIFO
HDR_FIFO_SIZE, 2, log2 depth of each lane header FIFO

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous flush of all FIFOs and packet tracking
next_dst  in  16*NUM_CH  per-lane destination SID; lane k uses [16k+15:16k]
i_tdata  in  NUM_CH*WIDTH  packed samples; lane k uses [(NUM_CH-k)*WIDTH-1 -: WIDTH] (lane 0 is the MSB slice)
i_tuser  in  128  CHDR header, held stable for the whole packet
i_tlast  in  1  end of input packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  NUM_CH*OW  lane outputs, OW = PAD_MODE ? 2*WIDTH : WIDTH; lane k at [OW*k+OW-1:OW*k]
o_tuser  out  128*NUM_CH  rewritten header per lane; lane k at [128k+127:128k]
o_tlast  out  NUM_CH  per-lane last
o_tvalid  out  NUM_CH  per-lane valid
o_tready  in  NUM_CH  per-lane ready
hdr_overflow  out  1  sticky flag; cleared only by reset or clear

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset or clear values: all FIFOs empty, o_tvalid=0, sof=1, i_tready=0 while reset=1, hdr_overflow=0.
- Input acceptance: i_tready=1 iff every lane data FIFO is not full AND (sof=0 OR every lane header FIFO is not full).
- An input beat is accepted when i_tvalid & i_tready. The beat's slices are pushed to all NUM_CH data FIFOs in the same cycle, each tagged with i_tlast.
- sof register: set by reset/clear, cleared on any accepted beat, set again on an accepted beat with i_tlast=1.
- Header push: on an accepted beat with sof=1, the rewritten header is pushed to every lane header FIFO.
- Header rewrite for lane k (tuser layout [127:96] hdr word, [95:80] src SID, [79:64] dst SID, [63:0] time):
  - [127:96] unchanged.
  - src = {in[79:68], k[3:0]}.
  - dst = next_dst lane k, sampled at the push cycle.
  - [63:0] unchanged.
- Lane output:
  - o_tvalid[k] = data FIFO k not empty.
  - o_tdata and o_tlast come from the data FIFO head.
  - o_tuser[k] comes from the header FIFO k head.
  - On o_tvalid[k] & o_tready[k] & o_tlast[k], header FIFO k pops.
- Latency: first-word-fall-through; one cycle from input accept to o_tvalid.
- Lanes are fully independent. A stalled lane blocks input only once its FIFO fills.
- Simultaneous push and pop on a FIFO in the same cycle is legal at any occupancy, including full, and occupancy is unchanged.
- Header FIFO empty while the data FIFO is not empty is impossible by construction. If it is detected, set hdr_overflow and present an all-zero o_tuser.
- next_dst changing mid-packet has no effect on packets already pushed.
- clear or reset mid-packet: in-flight beats are discarded, sof=1, and the next accepted beat starts a new packet.
- Throughput: one beat per cycle when all o_tready=1.

Test Plan:
- NUM_CH=2, WIDTH=16, PAD_MODE=1; send a 4-beat packet with i_tdata=32'hAAAA_5555, i_tuser[95:64]=32'h0012_0034, next_dst={16'h0056,16'h0078} -> lane0 o_tdata=32'hAAAA_0000 with src=16'h0030, dst=16'h0078; lane1 o_tdata=32'h5555_0000 with src=16'h0031, dst=16'h0056. Each lane emits 4 beats, tlast on beat 4, time field unchanged.
- Hold o_tready[1]=0 and o_tready[0]=1 while streaming 1-beat packets -> lane0 keeps flowing; i_tready falls after 32 accepted beats (lane1 data FIFO full) or after 4 packets (header FIFO full), whichever comes first. Releasing lane1 drains in order with matching headers.
- Back-to-back 1-beat packets with all o_tready=1 -> one beat per cycle, each packet carries its own header, no bubbles.
- Change next_dst during beat 2 of a 3-beat packet -> that packet keeps the old dst; the next packet carries the new dst.
- Assert clear after 2 of 5 beats with lanes stalled -> all o_tvalid=0 next cycle; the following packet's first beat is treated as sof and its header is correct.
- NUM_CH=4, WIDTH=8, PAD_MODE=0, i_tdata=32'h1122_3344 -> lane outputs 8'h11, 8'h22, 8'h33, 8'h44 with src port nibbles 0, 1, 2, 3.
